// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : timer_ctrl_pkg
// Brief  : Shared constants and FSM state encoding for the keypad entry path.
// Rev    : 1.0  initial release
// ============================================================================
package timer_ctrl_pkg;

  localparam int unsigned C_NUM_DIGITS   = 4;
  localparam logic [3:0]  C_KEY_START    = 4'hA;
  localparam logic [3:0]  C_KEY_CANCEL   = 4'hB;
  localparam logic [3:0]  C_SEC_TENS_MAX = 4'd5;
  localparam logic [3:0]  C_LAST_DIGIT   = 4'd9;

  // Hold counter saturates here; four stable cycles accept a key.
  localparam int unsigned C_HOLD_WIDTH = 3;
  localparam int unsigned C_HOLD_MAX   = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE         = 2'd0;
  localparam state_t ST_DEBOUNCE     = 2'd1;
  localparam state_t ST_WAIT_RELEASE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/non_recycling_counter.sv
`default_nettype none
// ============================================================================
// Module : non_recycling_counter
// Brief  : Saturating up-counter; done stays high once MAX is reached until clear.
// Rev    : 1.0  initial release
// ============================================================================
module non_recycling_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MAX   = 4
) (
  input  logic clock,
  input  logic clear,
  output logic done
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == WIDTH'(MAX));
  assign done     = w_at_max;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_count <= '0;
    end else if (!w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_entry_controller.sv
`default_nettype none
// ============================================================================
// Module : timer_entry_controller
// Brief  : Debounces keypad presses and builds a BCD mm:ss entry for the timer.
// Rev    : 1.0  initial release
// ============================================================================
module timer_entry_controller
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = C_NUM_DIGITS,
  parameter logic [3:0]  KEY_START  = C_KEY_START,
  parameter logic [3:0]  KEY_CANCEL = C_KEY_CANCEL
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic                              key_valid,
  input  logic [3:0]                        key_code,
  output logic [4*NUM_DIGITS-1:0]           entry_bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_count,
  output logic                              digit_loaded,
  output logic                              load_timer,
  output logic [4*NUM_DIGITS-1:0]           timer_value,
  output logic                              entry_error
);

  localparam int unsigned ENTRY_W = 4 * NUM_DIGITS;
  localparam int unsigned COUNT_W = $clog2(NUM_DIGITS + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_key;
  logic                 r_hold_clr;
  logic                 w_hold_clear;
  logic                 w_hold_done;
  logic [ENTRY_W-1:0]   r_entry_bcd;
  logic [COUNT_W-1:0]   r_entry_count;
  logic [ENTRY_W-1:0]   r_timer_value;
  logic                 r_digit_loaded;
  logic                 r_load_timer;
  logic                 r_entry_error;

  logic w_key_stable;
  logic w_fire;
  logic w_is_digit;
  logic w_full;
  logic w_do_digit;
  logic w_digit_err;
  logic w_start;
  logic w_start_err;
  logic w_do_load;
  logic w_do_clear;

  assign w_hold_clear = clear | r_hold_clr;

  non_recycling_counter #(
    .WIDTH (C_HOLD_WIDTH),
    .MAX   (C_HOLD_MAX)
  ) u_hold (
    .clock (clock),
    .clear (w_hold_clear),
    .done  (w_hold_done)
  );

  // State register
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (key_valid) w_state_next = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!w_key_stable)    w_state_next = ST_IDLE;
        else if (w_hold_done) w_state_next = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!key_valid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Action decode: at most one of the pulse sources is active per press
  always_comb begin
    w_key_stable = key_valid && (key_code == r_key);
    w_fire       = (r_state == ST_DEBOUNCE) && w_key_stable && w_hold_done;
    w_is_digit   = (r_key <= C_LAST_DIGIT);
    w_full       = (r_entry_count == COUNT_W'(NUM_DIGITS));
    w_do_digit   = w_fire && w_is_digit && !w_full;
    w_digit_err  = w_fire && w_is_digit && w_full;
    w_start      = w_fire && (r_key == KEY_START);
    w_start_err  = w_start && ((r_entry_count == '0) || (r_entry_bcd[7:4] > C_SEC_TENS_MAX));
    w_do_load    = w_start && !w_start_err;
    w_do_clear   = (w_fire && (r_key == KEY_CANCEL)) || w_do_load;
  end

  // Key latch and hold-counter release control
  always_ff @(posedge clock) begin
    if (clear) begin
      r_key      <= '0;
      r_hold_clr <= 1'b1;
    end else begin
      if ((r_state == ST_IDLE) && key_valid) begin
        r_key      <= key_code;
        r_hold_clr <= 1'b0;
      end else if ((r_state == ST_DEBOUNCE) && (!w_key_stable || w_hold_done)) begin
        r_hold_clr <= 1'b1;
      end
    end
  end

  // Entry datapath and registered pulses
  always_ff @(posedge clock) begin
    if (clear) begin
      r_entry_bcd    <= '0;
      r_entry_count  <= '0;
      r_timer_value  <= '0;
      r_digit_loaded <= 1'b0;
      r_load_timer   <= 1'b0;
      r_entry_error  <= 1'b0;
    end else begin
      r_digit_loaded <= w_do_digit;
      r_load_timer   <= w_do_load;
      r_entry_error  <= w_digit_err || w_start_err;
      if (w_do_load) begin
        r_timer_value <= r_entry_bcd;
      end
      if (w_do_clear) begin
        r_entry_bcd   <= '0;
        r_entry_count <= '0;
      end else if (w_do_digit) begin
        r_entry_bcd   <= {r_entry_bcd[ENTRY_W-5:0], r_key};
        r_entry_count <= r_entry_count + 1'b1;
      end
    end
  end

  assign entry_bcd    = r_entry_bcd;
  assign entry_count  = r_entry_count;
  assign timer_value  = r_timer_value;
  assign digit_loaded = r_digit_loaded;
  assign load_timer   = r_load_timer;
  assign entry_error  = r_entry_error;

endmodule
`default_nettype wire

// File: tb/tb_timer_entry_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_timer_entry_controller
// Brief  : Directed self-checking bench for the keypad entry controller.
// Rev    : 1.0  initial release
// ============================================================================
module tb_timer_entry_controller;

  logic        clock;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_bcd;
  logic [2:0]  entry_count;
  logic        digit_loaded;
  logic        load_timer;
  logic [15:0] timer_value;
  logic        entry_error;

  int checks = 0;
  int errors = 0;

  // Pulse values captured at the action cycle (p_*) and the cycle after (q_any)
  logic p_dl, p_lt, p_ee, q_any;

  timer_entry_controller dut (
    .clock        (clock),
    .clear        (clear),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .entry_bcd    (entry_bcd),
    .entry_count  (entry_count),
    .digit_loaded (digit_loaded),
    .load_timer   (load_timer),
    .timer_value  (timer_value),
    .entry_error  (entry_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hold a key for six edges, capture pulses, then release back to IDLE.
  task automatic press(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    p_dl = digit_loaded;
    p_lt = load_timer;
    p_ee = entry_error;
    key_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    q_any = digit_loaded | load_timer | entry_error;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    checks++;
    if ({entry_bcd, entry_count, timer_value, digit_loaded, load_timer, entry_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got entry=%h cnt=%0d tv=%h dl=%b lt=%b ee=%b, want all 0",
               entry_bcd, entry_count, timer_value, digit_loaded, load_timer, entry_error);
    end
    press(4'd8);
    checks++;
    if (entry_count !== 3'd1) begin
      errors++; $display("FAIL pre_clear_count: got %0d want 1", entry_count);
    end
    // Clear in the middle of a held press; the key stays held across it
    key_code = 4'd6; key_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({entry_bcd, entry_count, timer_value, digit_loaded, load_timer, entry_error} !== '0) begin
      errors++;
      $display("FAIL mid_clear_outputs: got entry=%h cnt=%0d, want 0", entry_bcd, entry_count);
    end
    clear = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checks++;
    if (digit_loaded !== 1'b0) begin
      errors++; $display("FAIL clear_restart_early: digit_loaded=%b after 5 edges want 0", digit_loaded);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (digit_loaded !== 1'b1 || entry_bcd !== 16'h0006) begin
      errors++;
      $display("FAIL clear_restart_load: dl=%b entry=%h want dl=1 entry=0006", digit_loaded, entry_bcd);
    end
    key_valid = 1'b0;
    repeat (2) @(posedge clock);
    // Return to an empty entry for the following tests
    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_digit();
    key_code = 4'd5; key_valid = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checks++;
    if (digit_loaded !== 1'b0 || entry_count !== 3'd0) begin
      errors++;
      $display("FAIL digit_latency_early: dl=%b cnt=%0d after 5 edges want 0/0", digit_loaded, entry_count);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (digit_loaded !== 1'b1 || entry_bcd !== 16'h0005 || entry_count !== 3'd1 ||
        load_timer !== 1'b0 || entry_error !== 1'b0) begin
      errors++;
      $display("FAIL digit_load: dl=%b entry=%h cnt=%0d lt=%b ee=%b want 1/0005/1/0/0",
               digit_loaded, entry_bcd, entry_count, load_timer, entry_error);
    end
    // Still held: pulse must drop and no second action
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++;
    if (digit_loaded !== 1'b0 || entry_count !== 3'd1) begin
      errors++;
      $display("FAIL digit_single_action: dl=%b cnt=%0d want 0/1", digit_loaded, entry_count);
    end
    key_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_bounce();
    logic seen;
    seen = 1'b0;
    key_code = 4'd4;
    for (int r = 0; r < 3; r++) begin
      key_valid = 1'b1;
      for (int e = 0; e < 3; e++) begin
        @(posedge clock); @(negedge clock);
        seen = seen | digit_loaded | load_timer | entry_error;
      end
      key_valid = 1'b0;
      @(posedge clock); @(negedge clock);
      seen = seen | digit_loaded | load_timer | entry_error;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    seen = seen | digit_loaded | load_timer | entry_error;
    checks++;
    if (seen !== 1'b0 || entry_bcd !== 16'h0005 || entry_count !== 3'd1) begin
      errors++;
      $display("FAIL bounce: pulse_seen=%b entry=%h cnt=%0d want 0/0005/1", seen, entry_bcd, entry_count);
    end
    press(4'hB);
  endtask

  task automatic test_load();
    press(4'd1); press(4'd3); press(4'd0); press(4'd0);
    checks++;
    if (entry_bcd !== 16'h1300 || entry_count !== 3'd4) begin
      errors++; $display("FAIL load_entry: entry=%h cnt=%0d want 1300/4", entry_bcd, entry_count);
    end
    press(4'hA);
    checks++;
    if (p_lt !== 1'b1 || p_dl !== 1'b0 || p_ee !== 1'b0 || q_any !== 1'b0) begin
      errors++;
      $display("FAIL load_pulse: lt=%b dl=%b ee=%b next=%b want 1/0/0/0", p_lt, p_dl, p_ee, q_any);
    end
    checks++;
    if (timer_value !== 16'h1300 || entry_bcd !== 16'h0000 || entry_count !== 3'd0) begin
      errors++;
      $display("FAIL load_values: tv=%h entry=%h cnt=%0d want 1300/0000/0", timer_value, entry_bcd, entry_count);
    end
  endtask

  task automatic test_bad_seconds();
    press(4'd7); press(4'd5);
    press(4'hA);
    checks++;
    if (p_ee !== 1'b1 || p_lt !== 1'b0 || entry_bcd !== 16'h0075 || timer_value !== 16'h1300) begin
      errors++;
      $display("FAIL bad_seconds: ee=%b lt=%b entry=%h tv=%h want 1/0/0075/1300",
               p_ee, p_lt, entry_bcd, timer_value);
    end
    press(4'hB);
    checks++;
    if (entry_bcd !== 16'h0000 || entry_count !== 3'd0 || (p_dl | p_lt | p_ee) !== 1'b0) begin
      errors++;
      $display("FAIL cancel: entry=%h cnt=%0d pulses=%b%b%b want 0000/0/000",
               entry_bcd, entry_count, p_dl, p_lt, p_ee);
    end
  endtask

  task automatic test_full_and_empty();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'd9);
    checks++;
    if (p_ee !== 1'b1 || p_dl !== 1'b0 || entry_bcd !== 16'h1234 || entry_count !== 3'd4) begin
      errors++;
      $display("FAIL entry_full: ee=%b dl=%b entry=%h cnt=%0d want 1/0/1234/4",
               p_ee, p_dl, entry_bcd, entry_count);
    end
    press(4'hB);
    press(4'hA);
    checks++;
    if (p_ee !== 1'b1 || p_lt !== 1'b0 || timer_value !== 16'h1300) begin
      errors++;
      $display("FAIL empty_start: ee=%b lt=%b tv=%h want 1/0/1300", p_ee, p_lt, timer_value);
    end
  endtask

  task automatic test_unused_and_minutes();
    press(4'hD);
    checks++;
    if ((p_dl | p_lt | p_ee) !== 1'b0 || entry_count !== 3'd0) begin
      errors++;
      $display("FAIL unused_key: pulses=%b%b%b cnt=%0d want 000/0", p_dl, p_lt, p_ee, entry_count);
    end
    // Minutes are unrestricted; seconds tens of 5 is the upper legal value
    press(4'd9); press(4'd9); press(4'd5); press(4'd9);
    press(4'hA);
    checks++;
    if (p_lt !== 1'b1 || p_ee !== 1'b0 || timer_value !== 16'h9959 || entry_count !== 3'd0) begin
      errors++;
      $display("FAIL max_time_load: lt=%b ee=%b tv=%h cnt=%0d want 1/0/9959/0",
               p_lt, p_ee, timer_value, entry_count);
    end
    // Seconds tens of 6 is the first rejected value
    press(4'd6); press(4'd0);
    press(4'hA);
    checks++;
    if (p_ee !== 1'b1 || p_lt !== 1'b0 || entry_bcd !== 16'h0060 || timer_value !== 16'h9959) begin
      errors++;
      $display("FAIL sec_tens_6: ee=%b lt=%b entry=%h tv=%h want 1/0/0060/9959",
               p_ee, p_lt, entry_bcd, timer_value);
    end
  endtask

  initial begin
    clear = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    @(negedge clock);
    test_reset();
    test_digit();
    test_bounce();
    test_load();
    test_bad_seconds();
    test_full_and_empty();
    test_unused_and_minutes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
